// File: rtl/mul_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier: op encodings,
// FSM state encoding and iteration count.
package mul_pkg;

    localparam int XLEN  = 64;
    localparam int ITER  = (XLEN + 2) / 2;
    localparam int CNT_W = 6;

    localparam logic [2:0] MUL_OP_MUL    = 3'd0;
    localparam logic [2:0] MUL_OP_MULH   = 3'd1;
    localparam logic [2:0] MUL_OP_MULHSU = 3'd2;
    localparam logic [2:0] MUL_OP_MULHU  = 3'd3;
    localparam logic [2:0] MUL_OP_MULW   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // Reserved encodings behave as plain MUL.
    function automatic logic [2:0] norm_op(input logic [2:0] op);
        return (op > MUL_OP_MULW) ? MUL_OP_MUL : op;
    endfunction

endpackage

// File: rtl/add64.sv
// 64-bit adder with carry in and carry out; two are chained to build the
// 128-bit Booth accumulate.
module add64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        c0,
    output logic [63:0] s,
    output logic        co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {64'd0, c0};

endmodule

// File: rtl/booth_sel.sv
// Radix-4 Booth partial-product selector. Negative selections return the
// inverted operand; the caller supplies the +1 through the adder carry-in.
module booth_sel (
    input  logic [2:0]   triple,
    input  logic [127:0] mcand,
    output logic [127:0] operand,
    output logic         neg
);

    always_comb begin
        operand = '0;
        neg     = 1'b0;
        case (triple)
            3'b001, 3'b010: operand = mcand;
            3'b011:         operand = {mcand[126:0], 1'b0};
            3'b100: begin
                operand = ~{mcand[126:0], 1'b0};
                neg     = 1'b1;
            end
            3'b101, 3'b110: begin
                operand = ~mcand;
                neg     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mul_booth_iter.sv
// Iterative radix-4 Booth multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW.
// Optional macro MUL_ZERO_BYPASS_EN: zero operands skip straight to DONE.
module mul_booth_iter
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  mul_op,
    input  logic [63:0] op1,
    input  logic [63:0] op2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic [1:0]  state_dbg
);

    // Handshake: a request transfers on an edge where in_valid && in_ready
    // (and no flush); a result transfers on an edge where out_valid && out_ready.
    // Once raised, out_valid and result hold until that transfer or a flush.

    mul_state_e state, state_nxt;

    logic [127:0] acc;
    logic [127:0] mcand_q;
    logic [66:0]  mplier_q;
    logic [2:0]   op_q;
    logic [CNT_W-1:0] cnt;

    logic [2:0]   op_n;
    logic         mcand_sx, mplier_sx;
    logic [127:0] mcand_ext;
    logic [65:0]  mplier_ext;
    logic         zero_req;

    logic [127:0] pp_operand;
    logic         pp_neg;
    logic [63:0]  sum_lo, sum_hi;
    logic         carry_lo, carry_hi_unused;
    logic         last_step;

    assign op_n       = norm_op(mul_op);
    assign mcand_sx   = (op_n != MUL_OP_MULHU);
    assign mplier_sx  = (op_n == MUL_OP_MUL) || (op_n == MUL_OP_MULH) || (op_n == MUL_OP_MULW);
    assign mcand_ext  = {{64{mcand_sx & op1[63]}}, op1};
    assign mplier_ext = {{2{mplier_sx & op2[63]}}, op2};
    assign last_step  = (cnt == CNT_W'(ITER - 1));

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_req = (op1 == 64'd0) || (op2 == 64'd0);
`else
    assign zero_req = 1'b0;
`endif

    booth_sel u_booth_sel (
        .triple  (mplier_q[2:0]),
        .mcand   (mcand_q),
        .operand (pp_operand),
        .neg     (pp_neg)
    );

    // Low carry feeds the high c0; the carry out of bit 127 is dropped.
    add64 u_add_lo (
        .a  (acc[63:0]),
        .b  (pp_operand[63:0]),
        .c0 (pp_neg),
        .s  (sum_lo),
        .co (carry_lo)
    );

    add64 u_add_hi (
        .a  (acc[127:64]),
        .b  (pp_operand[127:64]),
        .c0 (carry_lo),
        .s  (sum_hi),
        .co (carry_hi_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = zero_req ? ST_DONE : ST_BUSY;
            ST_BUSY: if (last_step) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            op_q     <= MUL_OP_MUL;
            cnt      <= '0;
        end else if (!flush) begin
            if (state == ST_IDLE && in_valid) begin
                acc      <= '0;
                mcand_q  <= mcand_ext;
                mplier_q <= {mplier_ext, 1'b0};
                op_q     <= op_n;
                cnt      <= '0;
            end else if (state == ST_BUSY) begin
                acc      <= {sum_hi, sum_lo};
                mcand_q  <= {mcand_q[125:0], 2'b00};
                mplier_q <= {2'b00, mplier_q[66:2]};
                cnt      <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        case (op_q)
            MUL_OP_MUL:  result = acc[63:0];
            MUL_OP_MULW: result = {{32{acc[31]}}, acc[31:0]};
            default:     result = acc[127:64];
        endcase
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign state_dbg = state;

endmodule
